// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width, default oversampling.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Used by the receiver and intended to be shared with the matching transmitter so
// both ends agree on frame width and oversampling ratio.
package uart_pkg;

  localparam int DATA_BITS          = 8;
  localparam int BIT_CNT_W          = $clog2(DATA_BITS);
  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clk from i_d change to o_q change.
// Backpressure: none, free-running every clk.
//
// Ports:
//   clk     - sampling clock
//   reset_n - asynchronous active-low reset, both flops load RST_VAL
//   i_d     - asynchronous input
//   o_q     - synchronized output
module uart_sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, 8 data bits LSB first, 1 stop bit, optional even parity.
// Latency: rx_valid rises on the clk edge that registers the stop-bit sample tick.
// Backpressure: one-byte holding register; a byte arriving while it is unconsumed is dropped with overrun_err.
//
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit between data and stop).
//
// Ports:
//   clk         - system clock, rising edge
//   reset_n     - asynchronous active-low reset
//   baud_tick   - one-clk pulse at OVERSAMPLE x baud rate; all counters advance only on it
//   rx_pin      - asynchronous serial input, idle high
//   rx_ready    - consumer accepts rx_data when high together with rx_valid
//   rx_data     - received byte, stable while rx_valid is high
//   rx_valid    - rx_data holds an unconsumed byte
//   rx_busy     - receiver is inside a frame (any state but IDLE)
//   frame_err   - one-clk pulse: stop bit sampled low, byte discarded
//   parity_err  - one-clk pulse: even-parity mismatch (tied 0 without UART_RX_PARITY_EN)
//   overrun_err - one-clk pulse: new byte dropped because the previous one was not consumed
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 rx_pin,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int CNT_W = $clog2(OVERSAMPLE);

  rx_state_t              r_state;
  rx_state_t              w_state_nxt;
  logic [CNT_W-1:0]       r_smp_cnt;
  logic [CNT_W-1:0]       w_smp_nxt;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [BIT_CNT_W-1:0]   w_bit_nxt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   w_shift_nxt;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_rx_prev;
  logic                   r_frame_err;
  logic                   r_overrun_err;
  logic                   w_rx;
  logic                   w_half_done;
  logic                   w_bit_done;
  logic                   w_deliver;
  logic                   w_ferr;
`ifdef UART_RX_PARITY_EN
  logic                   r_parity_err;
  logic                   w_perr;
`endif

  uart_sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (rx_pin),
    .o_q     (w_rx)
  );

  // Start bit is checked at its centre; every later bit one full bit period on.
  assign w_half_done = (r_smp_cnt == CNT_W'(OVERSAMPLE / 2 - 1));
  assign w_bit_done  = (r_smp_cnt == CNT_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_smp_nxt   = r_smp_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        // Edge-triggered: a line stuck low after a bad frame cannot restart a frame.
        if (r_rx_prev && !w_rx) begin
          w_state_nxt = ST_START;
          w_smp_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          if (w_half_done) begin
            w_smp_nxt   = '0;
            w_bit_nxt   = '0;
            w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
          end else begin
            w_smp_nxt = r_smp_cnt + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (w_bit_done) begin
            w_smp_nxt   = '0;
            w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
            w_bit_nxt   = r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = ST_PARITY;
`else
              w_state_nxt = ST_STOP;
`endif
            end
          end else begin
            w_smp_nxt = r_smp_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          if (w_bit_done) begin
            w_smp_nxt   = '0;
            w_perr      = ^{r_shift, w_rx};
            w_state_nxt = ST_STOP;
          end else begin
            w_smp_nxt = r_smp_cnt + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (baud_tick) begin
          if (w_bit_done) begin
            w_smp_nxt   = '0;
            w_deliver   = w_rx;
            w_ferr      = !w_rx;
            w_state_nxt = ST_IDLE;
          end else begin
            w_smp_nxt = r_smp_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_smp_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_rx_prev     <= 1'b1;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_smp_cnt     <= w_smp_nxt;
      r_bit_cnt     <= w_bit_nxt;
      r_shift       <= w_shift_nxt;
      r_rx_prev     <= w_rx;
      r_frame_err   <= w_ferr;
      r_overrun_err <= w_deliver && r_valid && !rx_ready;
      // A delivery in the same clk as an acceptance refills the slot without a gap.
      if (w_deliver && (!r_valid || rx_ready)) begin
        r_data  <= w_shift_nxt;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_perr;
    end
  end
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign rx_busy     = (r_state != ST_IDLE);
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written corner sequences.
// Latency: baud_tick every 4 clk, OVERSAMPLE 16, so one bit = 64 clk.
// Backpressure: rx_ready is held low during frames and pulsed to consume each byte.
module tb_uart_rx;

  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLK  = OS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int NB_AFTER_START = 10;
`else
  localparam int NB_AFTER_START = 9;
`endif
  // Two sync flops plus edge detect put START one clk later; the stop-sample
  // tick then falls within one tick period of this many clk after the drive.
  localparam int LAT_MIN = TICK_DIV * (OS / 2 + OS * NB_AFTER_START);
  localparam int LAT_MAX = LAT_MIN + TICK_DIV - 1;

  logic       clk;
  logic       reset_n;
  logic       baud_tick;
  logic       rx_pin;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tdiv = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_ovr = 0;
  int n_rise = 0;
  int rise_cyc = 0;
  int t_start = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .baud_tick   (baud_tick),
    .rx_pin      (rx_pin),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      baud_tick = (tdiv == TICK_DIV - 1);
      tdiv = (tdiv + 1) % TICK_DIV;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: pulse counters, rx_valid rise time, and scoreboard pop on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (frame_err === 1'b1)   n_ferr++;
      if (parity_err === 1'b1)  n_perr++;
      if (overrun_err === 1'b1) n_ovr++;
      if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
        n_rise++;
        rise_cyc = cyc;
      end
      prev_valid = rx_valid;
      if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got byte 0x%0h expected none", rx_data);
        end else begin
          check("sb_data", int'(rx_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    @(negedge clk);
    t_start = cyc;
    rx_pin = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx_pin = par;
    repeat (BIT_CLK) @(negedge clk);
`else
    if (par === 1'bz) rx_pin = 1'b1;
`endif
    rx_pin = stop;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic consume();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int f0, p0, o0, r0;

  task automatic snap();
    f0 = n_ferr;
    p0 = n_perr;
    o0 = n_ovr;
    r0 = n_rise;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 8'h81, 0};
    vecs[4] = '{8'hC3, 1'b0, 1'b0, 8'h00, 1};
    vecs[5] = '{8'h6E, 1'b1, 1'b1, 8'h6E, 0};

    reset_n  = 1'b0;
    rx_pin   = 1'b1;
    rx_ready = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("rst_data", int'(rx_data), 0);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_busy", int'(rx_busy), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_perr", int'(parity_err), 0);
    check("rst_ovr", int'(overrun_err), 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_busy", int'(rx_busy), 0);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      snap();
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].exp_data);
      send_frame(vecs[i].d, ^vecs[i].d, vecs[i].stop);
      repeat (8) @(negedge clk);
      #1;
      check($sformatf("v%0d_valid", i), int'(rx_valid), int'(vecs[i].exp_valid));
      check($sformatf("v%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
      check($sformatf("v%0d_perr", i), n_perr - p0, 0);
      check($sformatf("v%0d_ovr", i), n_ovr - o0, 0);
      check($sformatf("v%0d_busy", i), int'(rx_busy), 0);
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_data", i), int'(rx_data), int'(vecs[i].exp_data));
        check($sformatf("v%0d_rises", i), n_rise - r0, 1);
        check_range($sformatf("v%0d_latency", i), rise_cyc - t_start, LAT_MIN, LAT_MAX);
        consume();
        #1;
        check($sformatf("v%0d_valid_after_accept", i), int'(rx_valid), 0);
      end else begin
        check($sformatf("v%0d_rises", i), n_rise - r0, 0);
      end
      rx_pin = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end

    // Glitch: low for 4 ticks only, rejected at the start-bit centre.
    snap();
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("glitch_busy_mid", int'(rx_busy), 1);
    repeat (6) @(negedge clk);
    rx_pin = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    #1;
    check("glitch_busy_after", int'(rx_busy), 0);
    check("glitch_valid", int'(rx_valid), 0);
    check("glitch_flags", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);

    // Bad stop bit, then the line stays low for 40 ticks.
    snap();
    send_frame(8'h3C, ^8'h3C, 1'b0);
    repeat (40 * TICK_DIV) @(negedge clk);
    #1;
    check("ferr_pulses", n_ferr - f0, 1);
    check("ferr_valid", int'(rx_valid), 0);
    check("held_low_busy", int'(rx_busy), 0);
    rx_pin = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    #1;
    check("held_low_no_new_frame", n_ferr - f0 + n_rise - r0, 1);

    // Overrun: two bytes with rx_ready held low.
    snap();
    exp_q.push_back(8'h11);
    send_frame(8'h11, ^8'h11, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    repeat (8) @(negedge clk);
    #1;
    check("ovr_valid", int'(rx_valid), 1);
    check("ovr_data_kept", int'(rx_data), 8'h11);
    check("ovr_pulses", n_ovr - o0, 1);
    consume();
    #1;
    check("ovr_valid_after_accept", int'(rx_valid), 0);

`ifdef UART_RX_PARITY_EN
    snap();
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    #1;
    check("par_bad_perr", n_perr - p0, 1);
    check("par_bad_data", int'(rx_data), 8'h07);
    check("par_bad_valid", int'(rx_valid), 1);
    consume();
    snap();
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    #1;
    check("par_good_perr", n_perr - p0, 0);
    check("par_good_valid", int'(rx_valid), 1);
    consume();
`endif

    // Reset during bit 3 of 0xFF, then a clean 0x5A.
    snap();
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    rx_pin = 1'b1;
    repeat (3 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
    #1;
    check("pre_reset_busy", int'(rx_busy), 1);
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("mid_reset_busy", int'(rx_busy), 0);
    check("mid_reset_valid", int'(rx_valid), 0);
    reset_n = 1'b1;
    repeat (8 * BIT_CLK) @(negedge clk);
    #1;
    check("post_reset_no_byte", n_rise - r0, 0);
    check("post_reset_busy", int'(rx_busy), 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, ^8'h5A, 1'b1);
    repeat (8) @(negedge clk);
    #1;
    check("post_reset_valid", int'(rx_valid), 1);
    check("post_reset_data", int'(rx_data), 8'h5A);
    check("post_reset_flags", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);
    consume();

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter OVERSAMPLE, default 16, meaning baud ticks per bit period (even, >=8).
REQ-002 SHALL provide port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL provide port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
REQ-005 SHALL provide port rx_pin  input  1  asynchronous serial line, idle high.
REQ-006 SHALL provide port rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-007 SHALL provide port rx_data  output  8  received byte, stable while rx_valid high.
REQ-008 SHALL provide port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 SHALL provide port rx_busy  output  1  high in every state except IDLE.
REQ-010 SHALL provide ports frame_err, parity_err, overrun_err  output  1 each  one-clk error pulses.

Function
REQ-011 SHALL pass rx_pin through a 2-flop synchronizer; all decisions use the synchronized value only.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP; sample counter and bit counter advance only on baud_tick.
REQ-013 IDLE: SHALL enter START only on a synchronized high-to-low transition; a line held low never retriggers.
REQ-014 START: after OVERSAMPLE/2 ticks SHALL sample; low -> DATA with counters cleared; high -> IDLE (glitch rejected, no flags).
REQ-015 DATA: SHALL sample every OVERSAMPLE ticks (bit centre), shift LSB first, 8 bits, then PARITY (macro defined) or STOP.
REQ-016 PARITY: SHALL sample after OVERSAMPLE ticks; pulse parity_err if data plus parity bit has odd count of ones; byte still delivered; then STOP.
REQ-017 STOP: SHALL sample after OVERSAMPLE ticks; high -> deliver byte; low -> pulse frame_err, discard byte; IDLE in both cases.
REQ-018 Delivery SHALL register rx_data and assert rx_valid on the clk after the stop-sample tick.
REQ-019 rx_valid SHALL remain high until a clk with rx_valid and rx_ready both high, then deassert next clk.
REQ-020 If delivery occurs while rx_valid high and rx_ready low, SHALL pulse overrun_err, keep old rx_data, drop new byte.
REQ-021 If delivery coincides with rx_ready acceptance, SHALL load the new byte and keep rx_valid high (no overrun).
REQ-022 SHALL ignore rx_pin activity between sample points; no resynchronization mid-frame.

Reset
REQ-023 reset_n low SHALL immediately force IDLE, counters 0, shift register 0, synchronizer flops 1.
REQ-024 Reset values SHALL be rx_data 0, rx_valid 0, rx_busy 0, frame_err 0, parity_err 0, overrun_err 0.
REQ-025 Reset mid-frame SHALL abandon the frame with no flags; after release a byte is received only after a fresh falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined SHALL compile in PARITY state and even-parity check (frame 1+8+1+1).
REQ-027 Macro UART_RX_PARITY_EN undefined SHALL omit PARITY; DATA goes directly to STOP (frame 1+8+1); parity_err tied 0.

Structure
REQ-028 Package uart_pkg SHALL hold the rx state enum, DATA_BITS=8, and default OVERSAMPLE constant shared with the transmitter.
REQ-029 Synchronizer SHALL be sub-module uart_sync_2ff (reset value parameterized, here 1).

Verification
REQ-030 0xA5, 8N1, baud_tick every 4 clk, OVERSAMPLE 16 -> rx_valid rises 1 clk after stop sample, rx_data=0xA5, no errors.
REQ-031 rx_pin low for 4 ticks then high -> returns to IDLE, rx_valid stays 0, no error pulse.
REQ-032 0x3C with stop bit driven low -> single frame_err pulse, rx_valid 0; line held low 40 ticks -> no new frame.
REQ-033 0x11 then 0x22, rx_ready held 0 -> rx_data=0x11 kept, overrun_err pulses once at second delivery.
REQ-034 UART_RX_PARITY_EN, 0x07 with parity bit 0 -> parity_err pulse, rx_data=0x07 delivered; parity bit 1 -> no error.
REQ-035 reset_n asserted during bit 3 of 0xFF, released, then 0x5A sent -> only 0x5A delivered, no flags.
